stream_minmax_tracker: RTL and testbench

//  Frame-based running min/max tracker for a valid-qualified sample stream.

---
 rtl/stream_minmax_pkg.sv | 19 +
 rtl/minmax_cmp.sv | 23 ++
 rtl/stream_minmax_tracker.sv | 171 +++++++++++++++++
 tb/tb_stream_minmax_tracker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_minmax_pkg.sv
// rtl/stream_minmax_pkg.sv - shared types and defaults for the stream min/max tracker
// Contents: frame state enum (EMPTY/RUN/DONE), its encoding constants,
// default sample and counter widths.
package stream_minmax_pkg;

    localparam logic [1:0] ENC_EMPTY = 2'd0;
    localparam logic [1:0] ENC_RUN   = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = ENC_EMPTY,
        ST_RUN   = ENC_RUN,
        ST_DONE  = ENC_DONE
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/minmax_cmp.sv
// rtl/minmax_cmp.sv - combinational less-than of two samples, signed or unsigned
// Ports:
//   a_i   in   WIDTH  left operand
//   b_i   in   WIDTH  right operand
//   lt_o  out  1      a_i < b_i under the selected ordering
// A greater-than is obtained by instancing with the operands swapped.
module minmax_cmp #(
    parameter int WIDTH      = 8,
    parameter int SIGNED_CMP = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             lt_o
);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned comparator serves both modes.
    localparam logic [WIDTH-1:0] BIAS = (SIGNED_CMP != 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                          : {WIDTH{1'b0}};

    assign lt_o = (a_i ^ BIAS) < (b_i ^ BIAS);

endmodule

// File: rtl/stream_minmax_tracker.sv
// rtl/stream_minmax_tracker.sv - frame-based running min/max/count tracker for a sample stream
// Optional feature macro: MINMAX_INDEX_EN (adds out_min_idx and its register).
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   clear        in   1      abort frame, return to EMPTY
//   in_valid     in   1      sample qualifier
//   in_data      in   WIDTH  sample
//   in_last      in   1      last sample of frame
//   out_valid    out  1      results valid (RUN or DONE)
//   out_min      out  WIDTH  running/final minimum
//   out_max      out  WIDTH  running/final maximum
//   out_count    out  CNT_W  samples in frame, saturating
//   out_ovf      out  1      sticky count saturation flag
//   frame_done   out  1      one-cycle pulse after the closing sample
//   out_min_idx  out  CNT_W  index of first minimum sample (MINMAX_INDEX_EN)
module stream_minmax_tracker
    import stream_minmax_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             frame_done
`ifdef MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] out_min_idx
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] min_q,   min_d;
    logic [WIDTH-1:0] max_q,   max_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic             done_q,  done_d;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0] idx_q,   idx_d;
`endif

    logic lt_min;
    logic gt_max;

    minmax_cmp #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp_min (
        .a_i  (in_data),
        .b_i  (min_q),
        .lt_o (lt_min)
    );

    // Operands swapped: max_q < in_data  <=>  in_data > max_q.
    minmax_cmp #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp_max (
        .a_i  (max_q),
        .b_i  (in_data),
        .lt_o (gt_max)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef MINMAX_INDEX_EN
        idx_d   = idx_q;
`endif
        if (clear) begin
            // Abort wins over a coincident sample; the sample is dropped.
            state_d = ST_EMPTY;
            valid_d = 1'b0;
            min_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
`ifdef MINMAX_INDEX_EN
            idx_d   = '0;
`endif
        end else if (in_valid) begin
            valid_d = 1'b1;
            done_d  = in_last;
            state_d = in_last ? ST_DONE : ST_RUN;
            if (state_q != ST_RUN) begin
                // EMPTY or DONE: this sample opens a new frame with no bubble.
                min_d = in_data;
                max_d = in_data;
                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                ovf_d = 1'b0;
`ifdef MINMAX_INDEX_EN
                idx_d = '0;
`endif
            end else begin
                if (lt_min) begin
                    min_d = in_data;
`ifdef MINMAX_INDEX_EN
                    // Old count equals this sample's zero-based index; once
                    // the counter is pinned the index can no longer be known.
                    if (cnt_q != CNT_MAX) begin
                        idx_d = cnt_q;
                    end
`endif
                end
                if (gt_max) begin
                    max_d = in_data;
                end
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MINMAX_INDEX_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef MINMAX_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign out_valid  = valid_q;
    assign out_min    = min_q;
    assign out_max    = max_q;
    assign out_count  = cnt_q;
    assign out_ovf    = ovf_q;
    assign frame_done = done_q;
`ifdef MINMAX_INDEX_EN
    assign out_min_idx = idx_q;
`endif

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// tb/tb_stream_minmax_tracker.sv - directed-vector bench for stream_minmax_tracker
module tb_stream_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic       last = 1'b0;
    logic [3:0] vmask = '0;   // {c2, u8, s8, w2}
    logic [3:0] cmask = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic       w2_valid, w2_ovf, w2_done;
    logic [1:0] w2_min, w2_max;
    logic [7:0] w2_cnt;
    logic       s8_valid, s8_ovf, s8_done;
    logic [7:0] s8_min, s8_max, s8_cnt;
    logic       u8_valid, u8_ovf, u8_done;
    logic [7:0] u8_min, u8_max, u8_cnt;
    logic       c2_valid, c2_ovf, c2_done;
    logic [7:0] c2_min, c2_max;
    logic [1:0] c2_cnt;
`ifdef MINMAX_INDEX_EN
    logic [7:0] w2_idx, s8_idx, u8_idx;
    logic [1:0] c2_idx;
`endif

    stream_minmax_tracker #(.WIDTH(2), .CNT_W(8), .SIGNED_CMP(0)) u_w2 (
        .clk(clk), .rst(rst), .clear(cmask[0]), .in_valid(vmask[0]),
        .in_data(data[1:0]), .in_last(last), .out_valid(w2_valid),
        .out_min(w2_min), .out_max(w2_max), .out_count(w2_cnt),
        .out_ovf(w2_ovf), .frame_done(w2_done)
`ifdef MINMAX_INDEX_EN
        , .out_min_idx(w2_idx)
`endif
    );

    stream_minmax_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED_CMP(1)) u_s8 (
        .clk(clk), .rst(rst), .clear(cmask[1]), .in_valid(vmask[1]),
        .in_data(data), .in_last(last), .out_valid(s8_valid),
        .out_min(s8_min), .out_max(s8_max), .out_count(s8_cnt),
        .out_ovf(s8_ovf), .frame_done(s8_done)
`ifdef MINMAX_INDEX_EN
        , .out_min_idx(s8_idx)
`endif
    );

    stream_minmax_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED_CMP(0)) u_u8 (
        .clk(clk), .rst(rst), .clear(cmask[2]), .in_valid(vmask[2]),
        .in_data(data), .in_last(last), .out_valid(u8_valid),
        .out_min(u8_min), .out_max(u8_max), .out_count(u8_cnt),
        .out_ovf(u8_ovf), .frame_done(u8_done)
`ifdef MINMAX_INDEX_EN
        , .out_min_idx(u8_idx)
`endif
    );

    stream_minmax_tracker #(.WIDTH(8), .CNT_W(2), .SIGNED_CMP(0)) u_c2 (
        .clk(clk), .rst(rst), .clear(cmask[3]), .in_valid(vmask[3]),
        .in_data(data), .in_last(last), .out_valid(c2_valid),
        .out_min(c2_min), .out_max(c2_max), .out_count(c2_cnt),
        .out_ovf(c2_ovf), .frame_done(c2_done)
`ifdef MINMAX_INDEX_EN
        , .out_min_idx(c2_idx)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one sample to the DUTs in mask m across one clock edge,
    // then return #1 after that edge with inputs idle.
    task automatic send(input logic [3:0] m, input logic [7:0] d, input logic l);
        vmask = m;
        data  = d;
        last  = l;
        @(posedge clk);
        #1;
        vmask = '0;
        last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] t1_data [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
    logic [1:0] t1_min  [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [1:0] t1_max  [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};

    initial begin
        // Reset
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_w2_valid", w2_valid, 0);
        check("rst_w2_cnt",   w2_cnt,   0);
        check("rst_s8_min",   s8_min,   0);
        check("rst_u8_max",   u8_max,   0);
        check("rst_c2_ovf",   c2_ovf,   0);
        check("rst_u8_done",  u8_done,  0);
`ifdef MINMAX_INDEX_EN
        check("rst_u8_idx",   u8_idx,   0);
`endif

        // 1: WIDTH=2 stream 1,1,1,0,3,2 (last on 2)
        for (int i = 0; i < 6; i++) begin
            send(4'b0001, {6'd0, t1_data[i]}, i == 5);
            check($sformatf("t1_min[%0d]", i), w2_min, t1_min[i]);
            check($sformatf("t1_max[%0d]", i), w2_max, t1_max[i]);
            check($sformatf("t1_cnt[%0d]", i), w2_cnt, i + 1);
            check($sformatf("t1_done[%0d]", i), w2_done, (i == 5) ? 1 : 0);
            check($sformatf("t1_valid[%0d]", i), w2_valid, 1);
        end
`ifdef MINMAX_INDEX_EN
        check("t1_idx", w2_idx, 3);
`endif
        idle_cycle();
        check("t1_done_after", w2_done, 0);
        check("t1_hold_min",   w2_min,  0);
        check("t1_hold_valid", w2_valid, 1);

        // 2: signed vs unsigned on 05, FE, 7F (last)
        send(4'b0110, 8'h05, 1'b0);
        send(4'b0110, 8'hFE, 1'b0);
        send(4'b0110, 8'h7F, 1'b1);
        check("t2_s_min",  s8_min,  8'hFE);
        check("t2_s_max",  s8_max,  8'h7F);
        check("t2_s_done", s8_done, 1);
        check("t2_u_min",  u8_min,  8'h05);
        check("t2_u_max",  u8_max,  8'hFE);
        check("t2_u_cnt",  u8_cnt,  3);

        // 3: ties 4,2,2,7 (last), seeded straight from DONE
        send(4'b0100, 8'd4, 1'b0);
        check("t3_seed_cnt", u8_cnt, 1);
        send(4'b0100, 8'd2, 1'b0);
        send(4'b0100, 8'd2, 1'b0);
        check("t3_min_tie", u8_min, 2);
        send(4'b0100, 8'd7, 1'b1);
        check("t3_min",  u8_min, 2);
        check("t3_max",  u8_max, 7);
        check("t3_cnt",  u8_cnt, 4);
        check("t3_done", u8_done, 1);
`ifdef MINMAX_INDEX_EN
        check("t3_idx",  u8_idx, 1);
`endif

        // 4: back-to-back frames A (9,3 last) then B (5 last)
        send(4'b0100, 8'd9, 1'b0);
        check("t4_a_done0", u8_done, 0);
        send(4'b0100, 8'd3, 1'b1);
        check("t4_a_done", u8_done, 1);
        check("t4_a_min",  u8_min, 3);
        check("t4_a_max",  u8_max, 9);
        check("t4_a_cnt",  u8_cnt, 2);
        send(4'b0100, 8'd5, 1'b1);
        check("t4_b_done", u8_done, 1);
        check("t4_b_min",  u8_min, 5);
        check("t4_b_max",  u8_max, 5);
        check("t4_b_cnt",  u8_cnt, 1);
        idle_cycle();
        check("t4_b_done_end", u8_done, 0);
        check("t4_b_hold",     u8_min, 5);

        // 5: clear together with a sample mid-frame
        send(4'b0100, 8'd10, 1'b0);
        send(4'b0100, 8'd20, 1'b0);
        cmask = 4'b0100;
        send(4'b0100, 8'd1, 1'b0);
        cmask = '0;
        check("t5_valid", u8_valid, 0);
        check("t5_min",   u8_min, 0);
        check("t5_max",   u8_max, 0);
        check("t5_cnt",   u8_cnt, 0);
        send(4'b0100, 8'd6, 1'b0);
        check("t5_reseed_valid", u8_valid, 1);
        check("t5_reseed_min",   u8_min, 6);
        check("t5_reseed_cnt",   u8_cnt, 1);

        // 6: CNT_W=2 saturation, then reset mid-frame
        for (int i = 1; i <= 5; i++) begin
            send(4'b1000, i[7:0], 1'b0);
            check($sformatf("t6_cnt[%0d]", i), c2_cnt, (i > 3) ? 3 : i);
            check($sformatf("t6_ovf[%0d]", i), c2_ovf, (i > 3) ? 1 : 0);
        end
        check("t6_min",  c2_min, 1);
        check("t6_max",  c2_max, 5);
        check("t6_done", c2_done, 0);
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        check("t6_rst_valid", c2_valid, 0);
        check("t6_rst_cnt",   c2_cnt, 0);
        check("t6_rst_ovf",   c2_ovf, 0);
        check("t6_rst_max",   c2_max, 0);
        check("t6_rst_u8",    u8_valid, 0);
        send(4'b1000, 8'd9, 1'b1);
        check("t6_after_cnt",  c2_cnt, 1);
        check("t6_after_done", c2_done, 1);
        check("t6_after_min",  c2_min, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
